// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between the CPU MEM stage and a
//   debug/loader port. The CPU has fixed priority; a saturating starvation
//   counter forces a pending debug request through after STARVE_MAX
//   consecutive CPU wins. When that happens while the CPU is requesting,
//   the CPU is stalled for the cycle and the conflict counter advances.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   cpu_rd/wr/addr/wdata/func3  CPU access (EX/MEM register outputs)
//   cpu_rdata, cpu_stall     CPU read data, MEM-stage hold
//   dbg_req/we/addr/wdata/func3 debug request (valid/ready handshake)
//   dbg_ready, dbg_ack       request accepted / one-cycle completion pulse
//   dbg_rdata                registered debug read data
//   mem_rd/wr/addr/wdata/func3  to datamemory
//   mem_rdata                from datamemory (combinational read)
//   conflict_cnt             saturating count of cpu_stall cycles
//
// state | meaning
// IDLE  | ready to accept a debug request
// PEND  | debug request captured, waiting for a memory slot
// RESP  | debug access done, dbg_ack asserted

module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_func3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  output logic                  dbg_ready,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  input  logic [2:0]            dbg_func3,
  output logic                  dbg_ack,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [SW-1:0]         r_starve_cnt;
  logic                  r_req_we;
  logic [DM_ADDRESS-1:0] r_req_addr;
  logic [DATA_W-1:0]     r_req_wdata;
  logic [2:0]            r_req_func3;
  logic                  r_dbg_ack;
  logic [DATA_W-1:0]     r_dbg_rdata;
  logic [CNT_W-1:0]      r_conflict_cnt;

  logic w_cpu_req;
  logic w_grant_dbg;
  logic w_cpu_stall;

  assign w_cpu_req   = cpu_rd | cpu_wr;
  // Reset gating keeps the port quiet during the reset cycle, which also
  // drops any pending request without a memory access.
  assign w_grant_dbg = !reset && (r_state == ST_PEND) &&
                       (!w_cpu_req || (r_starve_cnt == SW'(STARVE_MAX)));
  assign w_cpu_stall = w_grant_dbg && w_cpu_req;

  assign cpu_stall    = w_cpu_stall;
  assign dbg_ready    = !reset && (r_state == ST_IDLE);
  assign dbg_ack      = r_dbg_ack;
  assign dbg_rdata    = r_dbg_rdata;
  assign conflict_cnt = r_conflict_cnt;

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = '0;
    cpu_rdata = '0;
    if (!reset) begin
      if (w_grant_dbg) begin
        mem_rd    = !r_req_we;
        mem_wr    = r_req_we;
        mem_addr  = r_req_addr;
        mem_wdata = r_req_wdata;
        mem_func3 = r_req_func3;
      end else begin
        cpu_rdata = mem_rdata;
        if (w_cpu_req) begin
          mem_rd    = cpu_rd;
          mem_wr    = cpu_wr;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          mem_func3 = cpu_func3;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_starve_cnt   <= '0;
      r_req_we       <= 1'b0;
      r_req_addr     <= '0;
      r_req_wdata    <= '0;
      r_req_func3    <= '0;
      r_dbg_ack      <= 1'b0;
      r_dbg_rdata    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_dbg_ack <= 1'b0;
      if (w_cpu_stall && (r_conflict_cnt != {CNT_W{1'b1}}))
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (dbg_req) begin
            r_req_we    <= dbg_we;
            r_req_addr  <= dbg_addr;
            r_req_wdata <= dbg_wdata;
            r_req_func3 <= dbg_func3;
            r_state     <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_grant_dbg) begin
            r_starve_cnt <= '0;
            r_dbg_ack    <= 1'b1;
            if (!r_req_we)
              r_dbg_rdata <= mem_rdata;
            r_state      <= ST_RESP;
          end else if (r_starve_cnt != SW'(STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0]    cpu_func3;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req, dbg_ready, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [2:0]    dbg_func3;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [2:0]    mem_func3;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DATA_W(DW), .DM_ADDRESS(AW), .STARVE_MAX(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_func3(cpu_func3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_func3(dbg_func3), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // word-wide data memory model, combinational read
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int n_chk = 0;
  int n_err = 0;
  int stall_total = 0;
  int rd_total = 0;

  typedef struct {
    bit          rd;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // scoreboard consumer: each ack retires the oldest expected debug access
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (cpu_stall) stall_total++;
      if (mem_rd) rd_total++;
      if (dbg_ack) begin
        if (sb.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          if (e.rd) chk("sb_dbg_rdata", dbg_rdata, e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_starve(input logic [AW-1:0] a, input logic [31:0] exp_d,
                            input logic [CW-1:0] exp_conf);
    int stall_n = 0;
    int stall_at = -1;
    int ack_at = -1;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 9'h020;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = a;
    sb.push_back('{rd: 1'b1, d: exp_d});
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) dbg_req = 1'b0;
      #1;
      if (k == 1) begin
        chk("st_cpu_addr", 32'(mem_addr), 32'h020);
        chk("st_cpu_rd", 32'(mem_rd), 32'd1);
        chk("st_cpu_rdata", cpu_rdata, mem[9'h020]);
      end
      if (cpu_stall) begin
        stall_n++;
        stall_at = k;
        chk("st_dbg_addr", 32'(mem_addr), 32'(a));
        chk("st_stall_rdata", cpu_rdata, 32'd0);
      end
      if (dbg_ack) begin
        ack_at = k;
        break;
      end
    end
    chk("st_stall_n", 32'(stall_n), 32'd1);
    chk("st_stall_at", 32'(stall_at), 32'd5);
    chk("st_ack_at", 32'(ack_at), 32'd6);
    chk("st_conflict", 32'(conflict_cnt), 32'(exp_conf));
    cpu_rd = 1'b0;
  endtask

  initial begin
    int acc_n, ack_n;
    int acc_at[2];
    int ack_at[2];
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    reset = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 9'h005; cpu_wdata = 32'h5555; cpu_func3 = 3'b010;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_func3 = '0;

    // reset cycle: port quiet even with requests present
    step(); #1;
    chk("rst_ready", 32'(dbg_ready), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_conflict", 32'(conflict_cnt), 32'd0);
    reset = 1'b0; cpu_wr = 1'b0; dbg_req = 1'b0;
    step(); #1;
    chk("post_rst_ready", 32'(dbg_ready), 32'd1);

    // debug write, idle CPU
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h010; dbg_wdata = 32'hDEADBEEF; dbg_func3 = 3'b010;
    sb.push_back('{rd: 1'b0, d: 32'h0});
    #1;
    chk("w_accept_ready", 32'(dbg_ready), 32'd1);
    chk("w_no_issue_t", 32'(mem_wr), 32'd0);
    step(); dbg_req = 1'b0; #1;
    chk("w_mem_wr", 32'(mem_wr), 32'd1);
    chk("w_mem_rd", 32'(mem_rd), 32'd0);
    chk("w_mem_addr", 32'(mem_addr), 32'h010);
    chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("w_mem_func3", 32'(mem_func3), 32'd2);
    chk("w_ready_pend", 32'(dbg_ready), 32'd0);
    chk("w_ack_early", 32'(dbg_ack), 32'd0);
    step(); #1;
    chk("w_ack", 32'(dbg_ack), 32'd1);
    chk("w_mem_wr_resp", 32'(mem_wr), 32'd0);
    step(); #1;
    chk("w_stall_total", 32'(stall_total), 32'd0);
    chk("w_conflict", 32'(conflict_cnt), 32'd0);
    chk("w_mem_model", mem[9'h010], 32'hDEADBEEF);
    chk("w_ready_idle", 32'(dbg_ready), 32'd1);

    // debug read back
    rd_total = 0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010;
    sb.push_back('{rd: 1'b1, d: 32'hDEADBEEF});
    step(); dbg_req = 1'b0; #1;
    chk("r_mem_rd", 32'(mem_rd), 32'd1);
    step(); #1;
    chk("r_ack", 32'(dbg_ack), 32'd1);
    chk("r_rdata", dbg_rdata, 32'hDEADBEEF);
    step(); #1;
    chk("r_rd_once", 32'(rd_total), 32'd1);

    // starvation: CPU wins 4 times, debug forced on the 5th
    run_starve(9'h010, 32'hDEADBEEF, 16'd1);
    step(); #1;

    // CPU write then read, no debug activity
    cpu_wr = 1'b1; cpu_addr = 9'h020; cpu_wdata = 32'h12345678; cpu_func3 = 3'b100; #1;
    chk("c_mem_wr", 32'(mem_wr), 32'd1);
    chk("c_mem_addr", 32'(mem_addr), 32'h020);
    chk("c_mem_wdata", mem_wdata, 32'h12345678);
    chk("c_mem_func3", 32'(mem_func3), 32'd4);
    chk("c_stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_wr = 1'b0; cpu_rd = 1'b1; #1;
    chk("c_mem_rd", 32'(mem_rd), 32'd1);
    chk("c_rdata", cpu_rdata, 32'h12345678);
    cpu_rd = 1'b0; #1;
    chk("c_idle_addr", 32'(mem_addr), 32'd0);
    chk("c_idle_rd", 32'(mem_rd), 32'd0);

    // reset while a debug request is pending
    step();
    cpu_rd = 1'b1; cpu_addr = 9'h020;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h030; dbg_wdata = 32'h00000BAD;
    step(); dbg_req = 1'b0; #1;
    chk("p_cpu_granted", 32'(mem_addr), 32'h020);
    step();
    reset = 1'b1; #1;
    chk("p_rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("p_rst_ready", 32'(dbg_ready), 32'd0);
    step();
    reset = 1'b0; cpu_rd = 1'b0; #1;
    chk("p_ready_after", 32'(dbg_ready), 32'd1);
    chk("p_no_ack", 32'(dbg_ack), 32'd0);
    chk("p_conflict_clr", 32'(conflict_cnt), 32'd0);
    step(); #1;
    chk("p_no_ack2", 32'(dbg_ack), 32'd0);
    chk("p_no_write", mem[9'h030], 32'd0);
    // starvation counter must be back at zero: full 4 CPU wins again
    run_starve(9'h010, 32'hDEADBEEF, 16'd1);

    // request held through RESP: re-accepted only from IDLE
    step();
    acc_n = 0; ack_n = 0;
    acc_at[0] = -1; acc_at[1] = -1; ack_at[0] = -1; ack_at[1] = -1;
    sb.push_back('{rd: 1'b1, d: 32'hDEADBEEF});
    sb.push_back('{rd: 1'b1, d: 32'hDEADBEEF});
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        step();
        if (acc_n >= 2) dbg_req = 1'b0;
      end
      #1;
      if (dbg_req && dbg_ready) begin
        if (acc_n < 2) acc_at[acc_n] = k;
        acc_n++;
      end
      if (dbg_ack) begin
        if (ack_n < 2) ack_at[ack_n] = k;
        ack_n++;
      end
    end
    dbg_req = 1'b0;
    chk("h_acc_n", 32'(acc_n), 32'd2);
    chk("h_acc1_at", 32'(acc_at[1]), 32'd3);
    chk("h_ack_n", 32'(ack_n), 32'd2);
    chk("h_ack0_at", 32'(ack_at[0]), 32'd2);
    chk("h_ack_gap", 32'(ack_at[1] - ack_at[0]), 32'd3);

    step(); #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (CPU) and a debug/loader port used by the testbench and program loader.
- The CPU has fixed priority. A saturating starvation counter guarantees the debug port a slot.
- When the debug port takes the memory while the CPU is requesting, the arbiter stalls the CPU so the pipeline holds its MEM stage.
- The block sits between the EX/MEM register outputs and datamemory.

Parameters:
- DATA_W, 32, data width
- DM_ADDRESS, 9, data memory address width
- STARVE_MAX, 4, number of consecutive CPU wins after which a pending debug request is forced through
- CNT_W, 16, width of the conflict counter

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- cpu_rd  input  1  CPU read request (MemRead)
- cpu_wr  input  1  CPU write request (MemWrite)
- cpu_addr  input  DM_ADDRESS  CPU address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_func3  input  3  CPU access size/sign
- cpu_rdata  output  DATA_W  CPU read data
- cpu_stall  output  1  MEM stage must hold this cycle
- dbg_req  input  1  debug request valid
- dbg_ready  output  1  debug request accepted when dbg_req && dbg_ready
- dbg_we  input  1  debug write (1) / read (0)
- dbg_addr  input  DM_ADDRESS  debug address
- dbg_wdata  input  DATA_W  debug write data
- dbg_func3  input  3  debug access size/sign
- dbg_ack  output  1  one-cycle completion pulse
- dbg_rdata  output  DATA_W  registered debug read data
- mem_rd  output  1  to datamemory MemRead
- mem_wr  output  1  to datamemory MemWrite
- mem_addr  output  DM_ADDRESS  to datamemory
- mem_wdata  output  DATA_W  to datamemory
- mem_func3  output  3  to datamemory
- mem_rdata  input  DATA_W  from datamemory; combinational read, valid in the same cycle as mem_rd
- conflict_cnt  output  CNT_W  saturating count of cpu_stall cycles

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- FSM states: IDLE, PEND, RESP.
- IDLE:
  - dbg_ready=1.
  - On dbg_req: capture dbg_we, dbg_addr, dbg_wdata and dbg_func3 into a request register, then go to PEND.
  - A captured request is never issued in its acceptance cycle; earliest issue is the next cycle.
- PEND:
  - dbg_ready=0.
  - Definition: cpu_req = cpu_rd | cpu_wr.
  - grant_dbg = !cpu_req || (starve_cnt == STARVE_MAX).
  - If grant_dbg: drive the memory from the request register, capture mem_rdata into dbg_rdata (reads only; writes leave dbg_rdata unchanged), clear starve_cnt, go to RESP.
  - Otherwise the CPU is granted and starve_cnt increments, saturating at STARVE_MAX.
- RESP:
  - dbg_ack=1 for exactly this cycle, dbg_ready=0.
  - Next state is IDLE unconditionally, so back-to-back debug requests are spaced at least 3 cycles apart.
- CPU grant (combinational):
  - Whenever the debug port is not granted, the mem_* outputs equal the cpu_* inputs and cpu_rdata = mem_rdata.
  - cpu_stall=0 in this case.
- Debug grant with CPU requesting:
  - cpu_stall=1 and conflict_cnt increments, saturating at 2^CNT_W-1.
  - The CPU must hold cpu_* stable; its access completes on the next non-stalled cycle.
- Idle port (no grant): mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, mem_func3=0.
- cpu_rdata while stalled: 0.
- Never both granted: at most one of the CPU or debug port drives memory per cycle. mem_rd and mem_wr are never both 1 from the debug path.
- CPU asserting both cpu_rd and cpu_wr: passed through unchanged; datamemory's behaviour defines the result.
- Reset:
  - state=IDLE, starve_cnt=0, dbg_ack=0, dbg_rdata=0, conflict_cnt=0.
  - All mem_* outputs are 0 during the reset cycle, cpu_stall=0 and dbg_ready=0.
  - dbg_ready=1 from the first cycle after reset.
- Reset mid-operation: a pending or in-RESP request is dropped with no ack and no memory access.
- dbg_req while not ready: ignored; the requester must hold it until accepted.

Test Plan:
- Reset, then idle CPU; debug write 0xDEADBEEF to addr 0x010 with func3=010 -> accepted at cycle t, mem_wr=1 with addr 0x010 at t+1, dbg_ack at t+2, cpu_stall never set, conflict_cnt=0.
- Debug read of addr 0x010 -> dbg_rdata=0xDEADBEEF when dbg_ack=1; mem_rd=1 for exactly one cycle.
- CPU continuously requesting reads and debug read pending (STARVE_MAX=4) -> CPU granted 4 cycles, debug issued on the 5th with cpu_stall=1 for 1 cycle, conflict_cnt=1, ack the next cycle.
- CPU write 0x12345678 to 0x020 with no debug activity -> mem_* mirror cpu_*; a following CPU read returns 0x12345678 same cycle on cpu_rdata; cpu_stall=0.
- reset asserted while in PEND -> no mem access issued, dbg_ack stays 0, dbg_ready=1 the cycle after reset deasserts, starve_cnt back to 0.
- dbg_req held through RESP -> not re-accepted until IDLE; two back-to-back requests produce acks ≥3 cycles apart.
